parity_calc: RTL and testbench
==============================

# parity_calc

Registered parity generator for a WIDTH-bit data word. Each rising clock edge samples `stream`, reduces it to one parity bit (even or odd sense, set by parameter) and presents it on `out`. Used as a leaf checker/generator on data buses, where a one-cycle registered result is acceptable.

## Interface

- `WIDTH`, default 10: data word width in bits; legal range 1..1024.
- `ODD`, default 0: parity sense.
  - 0: `out` = XOR of all bits (even parity bit).
  - 1: `out` = inverted XOR (odd parity bit).
- `clk` input 1: sole clock, rising-edge active.
- `rst_n` input 1: asynchronous, active-low reset; release is synchronised externally.
- `stream` input WIDTH: data word to be checked.
- `out` output 1: registered parity of `stream`.
- Port declaration order is fixed as `stream`, `clk`, `out`, `rst_n`, so positional instances that omit `rst_n` still bind correctly.
- Reset is asynchronous and active-low. Clock and reset names are `clk` and `rst_n`.

## Operation

- Combinational reduction: p = `stream[0]` ^ `stream[1]` ^ … ^ `stream[WIDTH-1]`, then p ^ ODD.
  - Implement as a balanced XOR tree of depth ceil(log2(WIDTH)).
  - No truncation. All WIDTH bits contribute.
- Output register: `out` is loaded with the reduction result on every rising `clk` edge.
  - No enable.
  - No hold state.
- Reset:
  - `rst_n` low forces `out` to 0 immediately, independent of `clk`.
  - The reset value is 0 for both values of ODD.
  - While `rst_n` is low, clock edges have no effect.
- X/Z on any `stream` bit propagates to `out`. No masking.
- No state machine; the only state is the `out` flop (plus the optional input register described under Configuration).

## Timing

- Latency: 1 clock. The `stream` value sampled at edge N appears on `out` after edge N and holds until edge N+1.
- Throughput: one new word per clock. Back-to-back words are always accepted; there is no handshake.
- `stream` must meet setup/hold around the rising edge. A change coincident with the edge is not a legal stimulus.
- Reset assertion mid-stream:
  - `out` goes to 0 asynchronously.
  - The first valid output follows the first rising edge after `rst_n` deasserts.
- WIDTH=1: `out` = `stream[0]` ^ ODD, with the same 1-cycle latency.

## Configuration

- Macro: `PARITY_CALC_IN_REG_EN`.
- Defined:
  - `stream` is first captured in a WIDTH-bit input register (reset to all zeros); the XOR tree reduces that register.
  - Latency becomes 2 clocks.
  - After reset release, the first edge outputs the parity of zero, i.e. ODD.
- Undefined: no input register, latency 1 clock as specified above.

## Test plan

- Reset: hold `rst_n`=0, toggle `clk`, drive `stream`=10'h3FF -> `out`=0 throughout. Assert `rst_n` low between edges -> `out` drops to 0 without a clock edge.
- Basic vectors, WIDTH=10, ODD=0. After one edge each:
  - `stream`=809 (1100101001) -> `out`=1
  - 810 -> 1
  - 811 -> 0
  - 0 -> 0
  - 10'h3FF -> 0
  - 10'h200 -> 1
- Incrementing sweep: start at 809, increment once per clock for 200 clocks -> `out` at each edge equals popcount(previous word) mod 2.
- Odd sense, ODD=1 -> inverted results:
  - `stream`=0 -> `out`=1
  - 809 -> 0
  - Reset still gives `out`=0.
- Extremes:
  - WIDTH=1: `stream`=1 -> `out`=1.
  - WIDTH=64: `stream`=64'hFFFF_FFFF_FFFF_FFFF -> 0; 64'h8000_0000_0000_0001 -> 0; 64'h1 -> 1.
- With `PARITY_CALC_IN_REG_EN` defined, `stream`=809 applied at edge N -> `out`=1 only after edge N+1. First post-reset output = ODD.

Source files
------------

// File: rtl/parity_calc.sv
// Registered even/odd parity of a WIDTH-bit word, reduced by a balanced XOR tree.
// Optional macro PARITY_CALC_IN_REG_EN adds a reset-to-zero input register (latency 2).
module parity_calc #(
  parameter int WIDTH = 10,
  parameter int ODD   = 0
) (
  input  logic [WIDTH-1:0] stream,
  input  logic             clk,
  output logic             out,
  input  logic             rst_n
);

  localparam int   LEVELS = $clog2(WIDTH);
  localparam logic SENSE  = (ODD != 0) ? 1'b1 : 1'b0;

  // Number of tree nodes remaining after l pairwise reduction stages.
  function automatic int level_cnt(input int l);
    int n;
    n = WIDTH;
    for (int k = 0; k < l; k++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  logic [WIDTH-1:0] data_s;
  logic             par_s;

`ifdef PARITY_CALC_IN_REG_EN
  logic [WIDTH-1:0] in_r;

  // Input capture register; the tree reduces the registered copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_r <= {WIDTH{1'b0}};
    end else begin
      in_r <= stream;
    end
  end

  assign data_s = in_r;
`else
  assign data_s = stream;
`endif

  // Each stage pairs neighbours; an odd leftover node passes straight up.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = level_cnt(l);
    logic [N-1:0] node_s;

    if (l == 0) begin : g_leaf
      assign node_s = data_s;
    end else begin : g_stage
      localparam int PN = level_cnt(l - 1);
      for (genvar i = 0; i < N; i++) begin : g_node
        if (2 * i + 1 < PN) begin : g_xor
          assign node_s[i] = g_lvl[l-1].node_s[2*i] ^ g_lvl[l-1].node_s[2*i+1];
        end else begin : g_pass
          assign node_s[i] = g_lvl[l-1].node_s[2*i];
        end
      end
    end
  end

  assign par_s = g_lvl[LEVELS].node_s[0] ^ SENSE;

  // Output flop; clears to 0 regardless of parity sense.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 1'b0;
    end else begin
      out <= par_s;
    end
  end

endmodule

// File: tb/tb_parity_calc.sv
// Randomised self-checking bench for parity_calc: four instances (W10 even/odd, W1, W64)
// compared each cycle against a popcount-based reference with a word history.
module tb_parity_calc;

`ifdef PARITY_CALC_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [9:0]  s10;
  logic [63:0] s64;
  logic [0:0]  s1;
  logic        o10e, o10o, o1, o64;

  int n_checks = 0;
  int n_pass   = 0;

  // Words sampled at the most recent edge (new) and the edge before (old).
  logic [9:0]  h10_new, h10_old;
  logic [63:0] h64_new, h64_old;
  logic        h1_new, h1_old;

  parity_calc #(.WIDTH(10), .ODD(0)) u_w10e (.stream(s10), .clk(clk), .out(o10e), .rst_n(rst_n));
  parity_calc #(.WIDTH(10), .ODD(1)) u_w10o (.stream(s10), .clk(clk), .out(o10o), .rst_n(rst_n));
  parity_calc #(.WIDTH(1),  .ODD(0)) u_w1   (.stream(s1),  .clk(clk), .out(o1),   .rst_n(rst_n));
  parity_calc #(.WIDTH(64), .ODD(0)) u_w64  (.stream(s64), .clk(clk), .out(o64),  .rst_n(rst_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_par(input logic [63:0] v);
    return ($countones(v) % 2 == 1) ? 1'b1 : 1'b0;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %b, expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_w10e"}, o10e, 1'b0);
    check({tag, "_w10o"}, o10o, 1'b0);
    check({tag, "_w1"},   o1,   1'b0);
    check({tag, "_w64"},  o64,  1'b0);
  endtask

  task automatic clear_hist();
    h10_new = 10'd0; h10_old = 10'd0;
    h64_new = 64'd0; h64_old = 64'd0;
    h1_new  = 1'b0;  h1_old  = 1'b0;
  endtask

  // Called #1 after an edge: apply words, clock once, compare against the model.
  task automatic drive_cycle(input logic [9:0] a, input logic [63:0] w, input logic b);
    logic [9:0]  e10;
    logic [63:0] e64;
    logic        e1;
    s10 = a; s64 = w; s1 = b;
    @(posedge clk);
    #1;
    h10_old = h10_new; h10_new = a;
    h64_old = h64_new; h64_new = w;
    h1_old  = h1_new;  h1_new  = b;
    e10 = (LAT == 2) ? h10_old : h10_new;
    e64 = (LAT == 2) ? h64_old : h64_new;
    e1  = (LAT == 2) ? h1_old  : h1_new;
    check("w10_even", o10e, ref_par({54'd0, e10}));
    check("w10_odd",  o10o, ~ref_par({54'd0, e10}));
    check("w1",       o1,   e1);
    check("w64",      o64,  ref_par(e64));
  endtask

  initial begin
    logic [9:0]  tbl10 [6];
    logic [63:0] tbl64 [3];
    logic [9:0]  v;
    tbl10[0] = 10'd809; tbl10[1] = 10'd810; tbl10[2] = 10'd811;
    tbl10[3] = 10'd0;   tbl10[4] = 10'h3FF; tbl10[5] = 10'h200;
    tbl64[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    tbl64[1] = 64'h8000_0000_0000_0001;
    tbl64[2] = 64'h0000_0000_0000_0001;

    // Reset held: clocks with all-ones data must leave every output at 0.
    rst_n = 1'b0; s10 = 10'h3FF; s64 = 64'hFFFF_FFFF_FFFF_FFFF; s1 = 1'b1;
    #2;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_all_zero("rst_hold");
    end
    rst_n = 1'b1;
    #1;
    check_all_zero("rst_release");
    clear_hist();

    for (int i = 0; i < 6; i++) begin
      drive_cycle(tbl10[i], tbl64[i % 3], (i % 2 == 0) ? 1'b1 : 1'b0);
    end

    v = 10'd809;
    for (int i = 0; i < 200; i++) begin
      drive_cycle(v, {$urandom, $urandom}, 1'($urandom));
      v = v + 10'd1;
    end

    for (int i = 0; i < 100; i++) begin
      drive_cycle(10'($urandom), {$urandom, $urandom}, 1'($urandom));
    end

    // Mid-stream asynchronous reset with a known-1 output beforehand.
    drive_cycle(10'h200, 64'h1, 1'b1);
    drive_cycle(10'h200, 64'h1, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    s10 = 10'h3FF; s64 = 64'h1; s1 = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all_zero("rst_mid_hold");
    end
    rst_n = 1'b1;
    clear_hist();
    drive_cycle(10'd809, 64'h1, 1'b1);
    drive_cycle(10'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(10'($urandom), {$urandom, $urandom}, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
